// File: rtl/sys_defs.sv
// Shared definitions for the memory arbiter slice: bus command encodings,
// memory tag width and the owner-table entry format.
package sys_defs;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam int MEM_TAG_W = 4;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_DCACHE = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic       vld;
    arb_owner_e owner;
  } owner_entry_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side and memory-side signals around the arbiter.
// slave: the arbiter's view; master: the surrounding caches and memory.
interface mem_arbiter_if;
  import sys_defs::*;

  logic [1:0]           icache2arb_command_i;
  logic [63:0]          icache2arb_addr_i;
  logic [MEM_TAG_W-1:0] arb2icache_response_o;
  logic [MEM_TAG_W-1:0] arb2icache_tag_o;
  logic [63:0]          arb2icache_data_o;

  logic [1:0]           dcache2arb_command_i;
  logic [63:0]          dcache2arb_addr_i;
  logic [63:0]          dcache2arb_data_i;
  logic [MEM_TAG_W-1:0] arb2dcache_response_o;
  logic [MEM_TAG_W-1:0] arb2dcache_tag_o;
  logic [63:0]          arb2dcache_data_o;

  logic [MEM_TAG_W-1:0] mem2proc_response;
  logic [63:0]          mem2proc_data;
  logic [MEM_TAG_W-1:0] mem2proc_tag;
  logic [1:0]           proc2mem_command;
  logic [63:0]          proc2mem_addr;
  logic [63:0]          proc2mem_data;

  logic [1:0]           arb_grant_o;

  modport slave (
    input  icache2arb_command_i, icache2arb_addr_i,
    output arb2icache_response_o, arb2icache_tag_o, arb2icache_data_o,
    input  dcache2arb_command_i, dcache2arb_addr_i, dcache2arb_data_i,
    output arb2dcache_response_o, arb2dcache_tag_o, arb2dcache_data_o,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
    output arb_grant_o
  );

  modport master (
    output icache2arb_command_i, icache2arb_addr_i,
    input  arb2icache_response_o, arb2icache_tag_o, arb2icache_data_o,
    output dcache2arb_command_i, dcache2arb_addr_i, dcache2arb_data_i,
    input  arb2dcache_response_o, arb2dcache_tag_o, arb2dcache_data_o,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
    input  arb_grant_o
  );

endinterface

// File: rtl/mem_arb_owner_tbl.sv
// Tag-indexed owner table: records which cache issued each outstanding load.
// An allocation and a free of the same tag in one cycle leave the entry
// valid with the new owner.
module mem_arb_owner_tbl
  import sys_defs::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_en,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  arb_owner_e           alloc_owner,
  input  logic                 free_en,
  input  logic [MEM_TAG_W-1:0] free_tag,
  input  logic [MEM_TAG_W-1:0] lookup_tag,
  output owner_entry_t         lookup_entry
);

  owner_entry_t entries [NUM_TAGS];

  // Free returning tags, then allocate newly accepted loads.
  // NOTE: the table is ownership state, not a data RAM; it must be reset so
  // that tags outstanding across a reset are treated as stray.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_TAGS; i++) entries[i] <= '0;
    end else begin
      if (free_en && free_tag != '0) entries[free_tag].vld <= 1'b0;
      // NOTE: non-blocking writes resolve in order, so the later allocation
      // overrides a same-tag free in the same cycle.
      if (alloc_en && alloc_tag != '0) entries[alloc_tag] <= '{vld: 1'b1, owner: alloc_owner};
    end
  end

  // Flag an allocation that lands on a live entry not being freed this cycle.
  always @(posedge clk) begin
    if (rst && alloc_en && alloc_tag != '0) begin
      a_alloc_overwrite: assert (!entries[alloc_tag].vld || (free_en && free_tag == alloc_tag));
    end
  end

  assign lookup_entry = entries[lookup_tag];

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between the Icache and the Dcache.
// Dcache has fixed priority; returning load data is routed by the owner table.
// Optional starvation guard for the Icache: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import sys_defs::*;
#(
  parameter int NUM_TAGS     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  logic         ic_req;
  logic         dc_req;
  logic         force_ic;
  logic         grant_ic;
  logic         grant_dc;
  logic [1:0]   gnt_cmd;
  logic         alloc_en;
  logic         free_en;
  owner_entry_t ret_entry;

  // Requests are ignored while reset is held, which forces every output idle.
  assign ic_req = rst && (bus.icache2arb_command_i != BUS_NONE);
  assign dc_req = rst && (bus.dcache2arb_command_i != BUS_NONE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign force_ic = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Count consecutive cycles the Icache asks and loses; saturates at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (ic_req && !grant_ic) begin
      if (!force_ic) starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end
`else
  assign force_ic = 1'b0;
`endif

  assign grant_dc = dc_req && !(force_ic && ic_req);
  assign grant_ic = ic_req && !grant_dc;

  // Forward the winner's command, address and data to memory.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    gnt_cmd               = BUS_NONE;
    bus.proc2mem_addr     = '0;
    bus.proc2mem_data     = '0;
    bus.arb2icache_response_o = '0;
    bus.arb2dcache_response_o = '0;
    if (grant_dc) begin
      gnt_cmd                   = bus.dcache2arb_command_i;
      bus.proc2mem_addr         = bus.dcache2arb_addr_i;
      bus.proc2mem_data         = bus.dcache2arb_data_i;
      bus.arb2dcache_response_o = bus.mem2proc_response;
    end else if (grant_ic) begin
      gnt_cmd                   = bus.icache2arb_command_i;
      bus.proc2mem_addr         = bus.icache2arb_addr_i;
      bus.arb2icache_response_o = bus.mem2proc_response;
    end
  end

  assign bus.proc2mem_command = gnt_cmd;
  assign bus.arb_grant_o      = {grant_dc, grant_ic};

  // Only accepted loads allocate; stores never produce a data return.
  assign alloc_en = (gnt_cmd == BUS_LOAD) && (bus.mem2proc_response != '0);
  assign free_en  = rst && (bus.mem2proc_tag != '0) && ret_entry.vld;

  mem_arb_owner_tbl #(
    .NUM_TAGS (NUM_TAGS)
  ) u_owner_tbl (
    .clk          (clk),
    .rst          (rst),
    .alloc_en     (alloc_en),
    .alloc_tag    (bus.mem2proc_response),
    .alloc_owner  (grant_dc ? OWN_DCACHE : OWN_ICACHE),
    .free_en      (free_en),
    .free_tag     (bus.mem2proc_tag),
    .lookup_tag   (bus.mem2proc_tag),
    .lookup_entry (ret_entry)
  );

  // Route the returning tag to its owner only; stray tags go nowhere.
  always_comb begin
    bus.arb2icache_tag_o = '0;
    bus.arb2dcache_tag_o = '0;
    if (free_en) begin
      if (ret_entry.owner == OWN_DCACHE) bus.arb2dcache_tag_o = bus.mem2proc_tag;
      else                               bus.arb2icache_tag_o = bus.mem2proc_tag;
    end
  end

  assign bus.arb2icache_data_o = bus.mem2proc_data;
  assign bus.arb2dcache_data_o = bus.mem2proc_data;

  // The Icache never writes memory.
  always @(posedge clk) begin
    if (rst) begin
      a_icache_no_store: assert (bus.icache2arb_command_i != BUS_STORE);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the stimulus pushes one expected record
// per driven cycle, a monitor pops and compares it on the falling edge.
module tb_mem_arbiter;
  import sys_defs::*;

  typedef struct {
    string       name;
    logic [3:0]  ic_resp;
    logic [3:0]  dc_resp;
    logic [3:0]  ic_tag;
    logic [3:0]  dc_tag;
    logic [1:0]  grant;
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [63:0] pdata;
    logic [63:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] ic_cmd, input logic [63:0] ic_addr,
                        input logic [1:0] dc_cmd, input logic [63:0] dc_addr,
                        input logic [63:0] dc_data, input logic [3:0] resp,
                        input logic [3:0] tag, input logic [63:0] mdata);
    bus.icache2arb_command_i = ic_cmd;
    bus.icache2arb_addr_i    = ic_addr;
    bus.dcache2arb_command_i = dc_cmd;
    bus.dcache2arb_addr_i    = dc_addr;
    bus.dcache2arb_data_i    = dc_data;
    bus.mem2proc_response    = resp;
    bus.mem2proc_tag         = tag;
    bus.mem2proc_data        = mdata;
  endtask

  // Push the expected outputs for the cycle just driven, then advance.
  task automatic expect_cycle(input string name, input logic [3:0] ic_resp,
                              input logic [3:0] dc_resp, input logic [3:0] ic_tag,
                              input logic [3:0] dc_tag, input logic [1:0] grant,
                              input logic [1:0] cmd, input logic [63:0] addr,
                              input logic [63:0] pdata);
    exp_t e;
    e.name    = name;
    e.ic_resp = ic_resp;
    e.dc_resp = dc_resp;
    e.ic_tag  = ic_tag;
    e.dc_tag  = dc_tag;
    e.grant   = grant;
    e.cmd     = cmd;
    e.addr    = addr;
    e.pdata   = pdata;
    e.rdata   = bus.mem2proc_data;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented cycle against the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".ic_resp"}, 64'(bus.arb2icache_response_o), 64'(e.ic_resp));
        check({e.name, ".dc_resp"}, 64'(bus.arb2dcache_response_o), 64'(e.dc_resp));
        check({e.name, ".ic_tag"},  64'(bus.arb2icache_tag_o),      64'(e.ic_tag));
        check({e.name, ".dc_tag"},  64'(bus.arb2dcache_tag_o),      64'(e.dc_tag));
        check({e.name, ".grant"},   64'(bus.arb_grant_o),           64'(e.grant));
        check({e.name, ".cmd"},     64'(bus.proc2mem_command),      64'(e.cmd));
        check({e.name, ".addr"},    bus.proc2mem_addr,              e.addr);
        check({e.name, ".pdata"},   bus.proc2mem_data,              e.pdata);
        check({e.name, ".ic_data"}, bus.arb2icache_data_o,          e.rdata);
        check({e.name, ".dc_data"}, bus.arb2dcache_data_o,          e.rdata);
      end
    end
  end

  initial begin
    logic [1:0] n;
    logic [1:0] l;
    logic [1:0] s;
    n = BUS_NONE;
    l = BUS_LOAD;
    s = BUS_STORE;

    set_in(n, 0, n, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Requests while reset is held are not granted.
    set_in(l, 64'h100, l, 64'h180, 0, 4'd1, 0, 0);
    expect_cycle("in_reset", 0, 0, 0, 0, 2'b00, n, 0, 0);
    rst = 1'b1;

    // Icache-only load, tag 3 returns two cycles later.
    set_in(l, 64'h100, n, 0, 0, 4'd3, 0, 0);
    expect_cycle("ic_load", 4'd3, 0, 0, 0, 2'b01, l, 64'h100, 0);
    set_in(n, 0, n, 0, 0, 0, 0, 0);
    expect_cycle("idle", 0, 0, 0, 0, 2'b00, n, 0, 0);
    set_in(n, 0, n, 0, 0, 0, 4'd3, 64'hDEAD);
    expect_cycle("ic_return", 0, 0, 4'd3, 0, 2'b00, n, 0, 0);
    set_in(n, 0, n, 0, 0, 0, 4'd3, 64'hBEEF);
    expect_cycle("freed_tag_stray", 0, 0, 0, 0, 2'b00, n, 0, 0);

    // Both request: Dcache store wins, store does not allocate.
    set_in(l, 64'h200, s, 64'h300, 64'h55, 4'd5, 0, 0);
    expect_cycle("both_req", 0, 4'd5, 0, 0, 2'b10, s, 64'h300, 64'h55);
    set_in(l, 64'h200, n, 0, 0, 4'd6, 4'd5, 64'h5);
    expect_cycle("store_tag_ret", 4'd6, 0, 0, 0, 2'b01, l, 64'h200, 0);

    // Memory rejects a Dcache load; the return of tag 6 is serviced alongside.
    set_in(n, 0, l, 64'h400, 0, 4'd0, 4'd6, 64'h66);
    expect_cycle("mem_reject", 0, 0, 4'd6, 0, 2'b10, l, 64'h400, 0);
    set_in(n, 0, l, 64'h400, 0, 4'd7, 0, 0);
    expect_cycle("dc_retry", 0, 4'd7, 0, 0, 2'b10, l, 64'h400, 0);
    set_in(n, 0, n, 0, 0, 0, 4'd7, 64'h77);
    expect_cycle("dc_return", 0, 0, 0, 4'd7, 2'b00, n, 0, 0);

    // Same-cycle return of tag 4 (Icache) and reallocation to Dcache.
    set_in(l, 64'h500, n, 0, 0, 4'd4, 0, 0);
    expect_cycle("ic_load4", 4'd4, 0, 0, 0, 2'b01, l, 64'h500, 0);
    set_in(n, 0, l, 64'h600, 0, 4'd4, 4'd4, 64'h44);
    expect_cycle("ret_alloc_same", 0, 4'd4, 4'd4, 0, 2'b10, l, 64'h600, 0);
    set_in(n, 0, n, 0, 0, 0, 4'd4, 64'h45);
    expect_cycle("realloc_return", 0, 0, 0, 4'd4, 2'b00, n, 0, 0);

    // Reset with tags 2 and 9 outstanding drops ownership.
    set_in(l, 64'h700, n, 0, 0, 4'd2, 0, 0);
    expect_cycle("ic_load2", 4'd2, 0, 0, 0, 2'b01, l, 64'h700, 0);
    set_in(n, 0, l, 64'h800, 0, 4'd9, 0, 0);
    expect_cycle("dc_load9", 0, 4'd9, 0, 0, 2'b10, l, 64'h800, 0);
    rst = 1'b0;
    set_in(n, 0, l, 64'h900, 0, 4'd10, 0, 0);
    expect_cycle("mid_reset", 0, 0, 0, 0, 2'b00, n, 0, 0);
    rst = 1'b1;
    set_in(n, 0, n, 0, 0, 0, 4'd9, 64'h99);
    expect_cycle("stray_tag9", 0, 0, 0, 0, 2'b00, n, 0, 0);
    set_in(n, 0, n, 0, 0, 0, 4'd2, 64'h22);
    expect_cycle("stray_tag2", 0, 0, 0, 0, 2'b00, n, 0, 0);
    set_in(n, 0, n, 0, 0, 0, 4'd10, 64'hAA);
    expect_cycle("stray_tag10", 0, 0, 0, 0, 2'b00, n, 0, 0);

    // Continuous contention: Dcache always wins unless the starvation guard
    // forces the Icache through after four losses.
    for (int c = 1; c <= 6; c++) begin
      set_in(l, 64'hB00, s, 64'hA00, 64'hAA, 4'd1, 0, 0);
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (c == 5) expect_cycle("starve_forced", 4'd1, 0, 0, 0, 2'b01, l, 64'hB00, 0);
      else        expect_cycle("starve_dc", 0, 4'd1, 0, 0, 2'b10, s, 64'hA00, 64'hAA);
`else
      expect_cycle("starve_dc", 0, 4'd1, 0, 0, 2'b10, s, 64'hA00, 64'hAA);
`endif
    end
    set_in(n, 0, n, 0, 0, 0, 4'd1, 64'h11);
`ifdef MEM_ARB_STARVE_GUARD_EN
    expect_cycle("starve_ret", 0, 0, 4'd1, 0, 2'b00, n, 0, 0);
`else
    expect_cycle("starve_ret", 0, 0, 0, 0, 2'b00, n, 0, 0);
`endif
    set_in(n, 0, n, 0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", sb.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single memory port (proc2mem_*/mem2proc_*) between the Icache and the Dcache.
- Selects one requester per cycle and forwards that request's command, address and data to memory.
- Returns the memory's accept tag to the winner only.
- Keeps a per-tag owner table so each load's data return reaches the requester that issued it.

Parameters:
- NUM_TAGS, 16, memory transaction tags; tag 0 means "no tag / rejected".
- STARVE_LIMIT, 4, consecutive lost Icache cycles before a forced Icache grant (optional feature only).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- icache2arb_command_i  in  2  BUS_NONE/BUS_LOAD; BUS_STORE from Icache is illegal
- icache2arb_addr_i  in  64  Icache request address
- arb2icache_response_o  out  4  accept tag for Icache; 0 = not accepted, retry
- arb2icache_tag_o  out  4  returning tag, nonzero only when Icache owns it
- arb2icache_data_o  out  64  mem2proc_data pass-through
- dcache2arb_command_i  in  2  BUS_NONE/BUS_LOAD/BUS_STORE
- dcache2arb_addr_i  in  64  Dcache request address
- dcache2arb_data_i  in  64  store data
- arb2dcache_response_o  out  4  accept tag for Dcache; 0 = retry
- arb2dcache_tag_o  out  4  returning tag, nonzero only when Dcache owns it
- arb2dcache_data_o  out  64  mem2proc_data pass-through
- mem2proc_response  in  4  memory accept tag, same cycle as command
- mem2proc_data  in  64  returning load data
- mem2proc_tag  in  4  tag of returning data; 0 = none
- proc2mem_command  out  2  granted command
- proc2mem_addr  out  64  granted address
- proc2mem_data  out  64  granted store data; 0 when Icache granted
- arb_grant_o  out  2  {dcache,icache} one-hot grant, 00 when idle

Behaviour:
Grant (combinational, same cycle):
- Dcache has fixed priority when its command is not BUS_NONE; otherwise Icache wins if its command is not BUS_NONE.
- The loser's response is 0 that cycle; it holds its request and retries.
- mem2proc_response is routed to the winner's response port; the other response port is 0.
- The winner is still told 0 when memory rejects the request.

Owner table (sequential, NUM_TAGS entries):
- Each entry holds {vld, owner}.
- On a clk edge where a granted BUS_LOAD gets mem2proc_response != 0: set entry[response] = {1, winner}.
- Stores do not allocate an entry.
- On a clk edge where mem2proc_tag != 0 and entry[mem2proc_tag].vld: clear that entry.

Data return (combinational):
- arb2{owner}_tag_o = mem2proc_tag when entry[mem2proc_tag].vld and the owner matches; the other side gets 0.
- When mem2proc_tag has no valid entry (stray or store tag), both tag outputs are 0.

Boundaries and invariants:
- Same-cycle return and new allocation of the same tag: allocation wins, and the entry ends valid with the new owner.
- Return and grant in the same cycle are independent; both are serviced.
- Tag 0 is never written to the table.
- An allocation onto an entry that is already valid overwrites it and is flagged by a simulation assertion.

Reset (rst low, asynchronous):
- All table entries are cleared and the starvation counter is zeroed.
- While in reset, the combinational outputs are forced to: proc2mem_command = BUS_NONE, all response/tag outputs 0, arb_grant_o = 00.
- A reset taken mid-transaction drops all ownership. Any later return of a pre-reset tag is stray and is not routed.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN
- Defined:
  - A saturating counter (width $clog2(STARVE_LIMIT+1)) increments each cycle the Icache requests and loses.
  - It clears when the Icache is granted or not requesting.
  - When the counter equals STARVE_LIMIT, the Icache takes priority for that cycle.
- Undefined: strict Dcache priority, no counter; the Icache can starve indefinitely.

Decomposition:
- Shared package (sys_defs):
  - BUS_NONE/BUS_LOAD/BUS_STORE encodings
  - MEM_TAG_W = 4
  - arb_owner_e enum {OWN_ICACHE, OWN_DCACHE}
  - owner-entry struct {vld, owner}
- One natural sub-module, mem_arb_owner_tbl: the tag-indexed owner table with alloc/free ports and same-cycle alloc-priority.
- Grant logic and the starvation counter stay in the top.

Test Plan:
- Icache-only load, addr 0x100, memory response 3; tag 3 returns 2 cycles later with data 0xDEAD → arb2icache_response_o = 3; arb2icache_tag_o = 3 with data 0xDEAD; arb2dcache_tag_o = 0.
- Both request in one cycle (Icache load 0x200, Dcache store 0x300 data 0x55), memory response 5 → proc2mem_command = BUS_STORE, addr 0x300, data 0x55; Dcache response 5; Icache response 0; no table entry for tag 5.
- Memory rejects a Dcache load (response 0) → Dcache response 0, no allocation; Dcache retries next cycle, response 7 → entry 7 owned by Dcache.
- Tag 4 owned by Icache returns in the same cycle Dcache load is accepted with tag 4 → Icache receives tag 4 that cycle; entry 4 afterwards valid with owner Dcache.
- rst asserted low with tags 2 and 9 outstanding, then released; memory returns tag 9 → both tag outputs 0, all entries invalid.
- With MEM_ARB_STARVE_GUARD_EN, Dcache requesting every cycle and Icache continuously requesting → Icache granted on the 5th cycle (after 4 losses); Dcache response 0 on that cycle.
